// File: rtl/accel_maxpool_pkg.sv
// accel_maxpool_pkg: pixel type and signed max shared by the max-pool stage
package accel_maxpool_pkg;

    localparam int ACCEL_DATA_W = 18;

    typedef logic signed [ACCEL_DATA_W-1:0] pix_t;

    function automatic pix_t smax(pix_t a, pix_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/accel_maxpool_if.sv
// accel_maxpool_if: pixel stream in, pooled stream out (to Writeback data/en)
interface accel_maxpool_if;
    import accel_maxpool_pkg::*;

    pix_t in_data;
    logic in_en;
    pix_t out_data;
    logic out_en;
    logic frame_done;

    modport master (output in_data, in_en, input out_data, out_en, frame_done);
    modport slave  (input in_data, in_en, output out_data, out_en, frame_done);

endinterface

// File: rtl/accel_maxpool_linebuf.sv
// accel_maxpool_linebuf: one row of pair maxima, sync write, combinational read, no reset
module accel_maxpool_linebuf
    import accel_maxpool_pkg::*;
#(
    parameter int DEPTH = 14,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  pix_t          wdata,
    input  logic [AW-1:0] raddr,
    output pix_t          rdata
);

    pix_t mem_q [DEPTH];

    // storage is always written before it is read within a frame, so no reset
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/accel_maxpool.sv
// accel_maxpool: 2x2 stride-2 max-pool with optional ReLU on a raster pixel stream
module accel_maxpool
    import accel_maxpool_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int RELU  = 1
) (
    input  logic             clk,
    input  logic             rst,
    accel_maxpool_if.slave   bus
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int AW = (CW > 1) ? CW - 1 : 1;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    pix_t          hold_q, hold_d;
    pix_t          out_data_q, out_data_d;
    logic          out_en_q, out_en_d;
    logic          done_q, done_d;
    pix_t          lb_rdata, pair_max, win_max;
    logic          lb_we, fire, last_col, last_row;
    logic [AW-1:0] lb_addr;

    // even rows park horizontal pair maxima here; odd rows read them back
    accel_maxpool_linebuf #(.DEPTH(IMG_W / 2), .AW(AW)) u_linebuf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (pair_max),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    // raster counters, window max and registered output, all gated by in_en
    always_comb begin
        last_col   = col_q == CW'(IMG_W - 1);
        last_row   = row_q == RW'(IMG_H - 1);
        lb_addr    = AW'(col_q >> 1);
        pair_max   = smax(hold_q, bus.in_data);
        win_max    = smax(pair_max, lb_rdata);
        lb_we      = bus.in_en && col_q[0] && !row_q[0];
        fire       = bus.in_en && col_q[0] && row_q[0];
        col_d      = !bus.in_en ? col_q : last_col ? '0 : col_q + 1'b1;
        row_d      = !(bus.in_en && last_col) ? row_q : last_row ? '0 : row_q + 1'b1;
        hold_d     = (bus.in_en && !col_q[0]) ? bus.in_data : hold_q;
        out_en_d   = fire;
        done_d     = fire && last_col && last_row;
        out_data_d = !fire ? out_data_q : (RELU != 0 && win_max[ACCEL_DATA_W-1]) ? '0 : win_max;
    end

    // state register; async active-low reset discards any partial window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q      <= '0;
            row_q      <= '0;
            hold_q     <= '0;
            out_data_q <= '0;
            out_en_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            hold_q     <= hold_d;
            out_data_q <= out_data_d;
            out_en_q   <= out_en_d;
            done_q     <= done_d;
        end
    end

    assign bus.out_data   = out_data_q;
    assign bus.out_en     = out_en_q;
    assign bus.frame_done = done_q;

endmodule
